// File: rtl/wb_sram16_ctrl_if.sv
//==============================================================================
// Module   : wb_sram16_ctrl_if
// Purpose  : Wishbone B4 classic bus bundle between the J1 interconnect
//            (master) and the 16-bit async SRAM controller (slave).
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

interface wb_sram16_ctrl_if #(
    parameter int ADDR_W = 18
);
    logic              cyc_i;
    logic              stb_i;
    logic              we_i;
    logic [ADDR_W-1:0] adr_i;
    logic [1:0]        sel_i;
    logic [15:0]       dat_i;
    logic [15:0]       dat_o;
    logic              ack_o;

    modport master (
        output cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
        input  dat_o, ack_o
    );

    modport slave (
        input  cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
        output dat_o, ack_o
    );
endinterface

`default_nettype wire

// File: rtl/wb_sram16_ctrl.sv
//==============================================================================
// Module   : wb_sram16_ctrl
// Purpose  : Wishbone B4 classic slave that turns one bus cycle into a timed
//            read or write on a 16-bit asynchronous SRAM, with programmable
//            read/write wait states and byte lanes taken from sel_i.
//            The SRAM data tristate lives in the top level (dq_o/dq_oe/dq_i).
// Options  : define WB_SRAM_TURNAROUND_EN to insert one bus-turnaround cycle
//            (all strobes high, data bus released) after every write.
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module wb_sram16_ctrl #(
    parameter int ADDR_W  = 18,
    parameter int RD_WAIT = 1,
    parameter int WR_WAIT = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    wb_sram16_ctrl_if.slave   wb,
    output logic [ADDR_W-1:0] sram_a,
    output logic [15:0]       sram_dq_o,
    output logic              sram_dq_oe,
    input  logic [15:0]       sram_dq_i,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sram_lb_n,
    output logic              sram_ub_n
);

    // Shared wait-state counter sized for the longer of the two waits
    localparam int c_CNT_MAX = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
    localparam int c_CNT_W   = (c_CNT_MAX < 2) ? 1 : $clog2(c_CNT_MAX + 1);

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_RD       = 3'd1;
    localparam logic [2:0] c_WR_SETUP = 3'd2;
    localparam logic [2:0] c_WR_PULSE = 3'd3;
    localparam logic [2:0] c_WR_HOLD  = 3'd4;
    localparam logic [2:0] c_ACK      = 3'd5;
`ifdef WB_SRAM_TURNAROUND_EN
    localparam logic [2:0] c_TURN     = 3'd6;
`endif

    logic [2:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [1:0]         r_sel;
    logic               r_abort;
`ifdef WB_SRAM_TURNAROUND_EN
    logic               r_was_wr;
`endif
    logic               r_ack;
    logic [15:0]        r_dat;
    logic [ADDR_W-1:0]  r_a;
    logic [15:0]        r_dq_o;
    logic               r_dq_oe;
    logic               r_ce_n;
    logic               r_oe_n;
    logic               r_we_n;
    logic               r_lb_n;
    logic               r_ub_n;

    logic               w_req;

    assign w_req = wb.cyc_i & wb.stb_i;

    // Access sequencer: every bus and SRAM output is a register of this FSM
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_sel   <= 2'b00;
            r_abort <= 1'b0;
`ifdef WB_SRAM_TURNAROUND_EN
            r_was_wr <= 1'b0;
`endif
            r_ack   <= 1'b0;
            r_dat   <= 16'h0000;
            r_a     <= '0;
            r_dq_o  <= 16'h0000;
            r_dq_oe <= 1'b0;
            r_ce_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_we_n  <= 1'b1;
            r_lb_n  <= 1'b1;
            r_ub_n  <= 1'b1;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_req) begin
                        // Latch the whole request; later bus changes are ignored
                        r_a    <= wb.adr_i;
                        r_sel  <= wb.sel_i;
                        r_dq_o <= wb.dat_i;
                        r_ce_n <= 1'b0;
`ifdef WB_SRAM_TURNAROUND_EN
                        r_was_wr <= wb.we_i;
`endif
                        if (wb.we_i) begin
                            r_dq_oe <= 1'b1;
                            r_state <= c_WR_SETUP;
                        end else begin
                            r_oe_n  <= 1'b0;
                            r_lb_n  <= ~wb.sel_i[0];
                            r_ub_n  <= ~wb.sel_i[1];
                            r_cnt   <= c_CNT_W'(RD_WAIT);
                            r_state <= c_RD;
                        end
                    end
                end

                c_RD: begin
                    if (!wb.cyc_i) begin
                        r_ce_n  <= 1'b1;
                        r_oe_n  <= 1'b1;
                        r_lb_n  <= 1'b1;
                        r_ub_n  <= 1'b1;
                        r_state <= c_IDLE;
                    end else if (r_cnt == '0) begin
                        r_dat   <= sram_dq_i;
                        r_ack   <= 1'b1;
                        r_ce_n  <= 1'b1;
                        r_oe_n  <= 1'b1;
                        r_lb_n  <= 1'b1;
                        r_ub_n  <= 1'b1;
                        r_state <= c_ACK;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_W'(1);
                    end
                end

                c_WR_SETUP: begin
                    if (!wb.cyc_i) begin
                        r_ce_n  <= 1'b1;
                        r_dq_oe <= 1'b0;
                        r_state <= c_IDLE;
                    end else begin
                        r_we_n  <= 1'b0;
                        r_lb_n  <= ~r_sel[0];
                        r_ub_n  <= ~r_sel[1];
                        r_cnt   <= c_CNT_W'(WR_WAIT);
                        r_state <= c_WR_PULSE;
                    end
                end

                c_WR_PULSE: begin
                    // An abort still finishes with a clean WE_n rise, data held
                    if (!wb.cyc_i || r_cnt == '0) begin
                        r_abort <= ~wb.cyc_i;
                        r_we_n  <= 1'b1;
                        r_state <= c_WR_HOLD;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_W'(1);
                    end
                end

                c_WR_HOLD: begin
                    r_ce_n  <= 1'b1;
                    r_lb_n  <= 1'b1;
                    r_ub_n  <= 1'b1;
                    r_dq_oe <= 1'b0;
                    r_abort <= 1'b0;
                    if (r_abort) begin
                        r_state <= c_IDLE;
                    end else begin
                        r_ack   <= 1'b1;
                        r_state <= c_ACK;
                    end
                end

                c_ACK: begin
                    r_ack <= 1'b0;
`ifdef WB_SRAM_TURNAROUND_EN
                    r_state <= r_was_wr ? c_TURN : c_IDLE;
`else
                    r_state <= c_IDLE;
`endif
                end

`ifdef WB_SRAM_TURNAROUND_EN
                c_TURN: begin
                    r_state <= c_IDLE;
                end
`endif

                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign wb.ack_o   = r_ack;
    assign wb.dat_o   = r_dat;
    assign sram_a     = r_a;
    assign sram_dq_o  = r_dq_o;
    assign sram_dq_oe = r_dq_oe;
    assign sram_ce_n  = r_ce_n;
    assign sram_oe_n  = r_oe_n;
    assign sram_we_n  = r_we_n;
    assign sram_lb_n  = r_lb_n;
    assign sram_ub_n  = r_ub_n;

endmodule

`default_nettype wire

// File: tb/tb_wb_sram16_ctrl.sv
//==============================================================================
// Module   : tb_wb_sram16_ctrl
// Purpose  : Directed self-checking bench for wb_sram16_ctrl with a simple
//            async SRAM model (byte-lane writes on the WE_n rising edge).
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_wb_sram16_ctrl;

    logic        clk_i;
    logic        rst_i;
    logic [17:0] sram_a;
    logic [15:0] sram_dq_o;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_i;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic        sram_lb_n;
    logic        sram_ub_n;

    wb_sram16_ctrl_if #(.ADDR_W(18)) wb_bus ();

    wb_sram16_ctrl #(
        .ADDR_W (18),
        .RD_WAIT(1),
        .WR_WAIT(1)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wb        (wb_bus),
        .sram_a    (sram_a),
        .sram_dq_o (sram_dq_o),
        .sram_dq_oe(sram_dq_oe),
        .sram_dq_i (sram_dq_i),
        .sram_ce_n (sram_ce_n),
        .sram_oe_n (sram_oe_n),
        .sram_we_n (sram_we_n),
        .sram_lb_n (sram_lb_n),
        .sram_ub_n (sram_ub_n)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // SRAM model
    logic [15:0] mem [0:(1<<18)-1];
    logic        prev_we_n = 1'b1;
    int          n_overlap = 0;

    assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_a] : 16'h0000;

    // Commit a write when WE_n rises with the chip still selected
    always @(negedge clk_i) begin
        if (prev_we_n == 1'b0 && sram_we_n == 1'b1 && sram_ce_n == 1'b0) begin
            if (!sram_lb_n) mem[sram_a][7:0]  = sram_dq_o[7:0];
            if (!sram_ub_n) mem[sram_a][15:8] = sram_dq_o[15:8];
        end
        prev_we_n = sram_we_n;
        if (!sram_oe_n && !sram_we_n) n_overlap++;
        if (sram_dq_oe && !sram_oe_n) n_overlap++;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Per-access observations
    int          t_ack_cyc;
    int          t_ce_fall;
    int          t_oe_low;
    int          t_we_low;
    logic [15:0] t_rdata;
    logic [15:0] t_dq;
    logic [17:0] t_a;
    logic [1:0]  t_lbub;

    // Issue one access from a negedge; returns at the negedge showing ack_o
    task automatic wb_access(input logic we, input logic [17:0] adr,
                             input logic [15:0] dat, input logic [1:0] sel);
        wb_bus.cyc_i = 1'b1;
        wb_bus.stb_i = 1'b1;
        wb_bus.we_i  = we;
        wb_bus.adr_i = adr;
        wb_bus.dat_i = dat;
        wb_bus.sel_i = sel;
        t_ack_cyc = -1; t_ce_fall = -1; t_oe_low = 0; t_we_low = 0;
        t_rdata = 16'h0; t_dq = 16'h0; t_a = 18'h0; t_lbub = 2'b11;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk_i);
            if (!sram_ce_n && t_ce_fall < 0) begin
                t_ce_fall = k;
                t_a = sram_a;
            end
            if (!sram_oe_n) t_oe_low++;
            if (!sram_we_n) begin
                if (t_we_low == 0) begin
                    t_lbub = {sram_ub_n, sram_lb_n};
                    t_dq   = sram_dq_o;
                end
                t_we_low++;
            end
            if (wb_bus.ack_o) begin
                t_ack_cyc = k;
                t_rdata   = wb_bus.dat_o;
                break;
            end
        end
        wb_bus.cyc_i = 1'b0;
        wb_bus.stb_i = 1'b0;
        wb_bus.we_i  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) @(negedge clk_i);
    endtask

    int acks;
    int waited;

    initial begin
        mem[18'h3FFFF] = 16'hA5C3;
        mem[18'h00000] = 16'h0000;
        mem[18'h00123] = 16'h0000;
        mem[18'h00200] = 16'h0000;
        rst_i = 1'b1;
        wb_bus.cyc_i = 1'b0; wb_bus.stb_i = 1'b0; wb_bus.we_i = 1'b0;
        wb_bus.adr_i = '0; wb_bus.dat_i = '0; wb_bus.sel_i = 2'b00;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check_value("rst_ack", {31'd0, wb_bus.ack_o}, 32'd0);
        check_value("rst_dat", {16'd0, wb_bus.dat_o}, 32'd0);
        check_value("rst_strobes", {27'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n}, 32'h1F);
        check_value("rst_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
        check_value("rst_addr", {14'd0, sram_a}, 32'd0);
        rst_i = 1'b0;
        idle(2);

        // Full-word write
        wb_access(1'b1, 18'h00123, 16'hBEEF, 2'b11);
        check_value("wr_ce_fall", t_ce_fall, 1);
        check_value("wr_we_low", t_we_low, 2);
        check_value("wr_dq", {16'd0, t_dq}, 32'hBEEF);
        check_value("wr_lanes", {30'd0, t_lbub}, 32'h0);
        check_value("wr_ack_cyc", t_ack_cyc, 5);
        check_value("wr_mem", {16'd0, mem[18'h00123]}, 32'hBEEF);
        idle(1);
        check_value("wr_ack_pulse", {31'd0, wb_bus.ack_o}, 32'd0);
        idle(1);

        // Read back
        wb_access(1'b0, 18'h00123, 16'h0000, 2'b11);
        check_value("rd_ce_fall", t_ce_fall, 1);
        check_value("rd_addr", {14'd0, t_a}, 32'h00123);
        check_value("rd_oe_low", t_oe_low, 2);
        check_value("rd_ack_cyc", t_ack_cyc, 3);
        check_value("rd_data", {16'd0, t_rdata}, 32'hBEEF);
        idle(1);
        check_value("rd_ack_pulse", {31'd0, wb_bus.ack_o}, 32'd0);
        idle(1);

        // Low-byte-only write
        wb_access(1'b1, 18'h00123, 16'h0012, 2'b01);
        check_value("wrlb_ack_cyc", t_ack_cyc, 5);
        check_value("wrlb_lanes", {30'd0, t_lbub}, 32'h2);
        idle(2);
        wb_access(1'b0, 18'h00123, 16'h0000, 2'b11);
        check_value("rdlb_data", {16'd0, t_rdata}, 32'hBE12);
        idle(2);

        // No byte lanes: sequence and ack still happen, memory untouched
        wb_access(1'b1, 18'h00123, 16'hFFFF, 2'b00);
        check_value("wr0_ack_cyc", t_ack_cyc, 5);
        check_value("wr0_we_low", t_we_low, 2);
        check_value("wr0_lanes", {30'd0, t_lbub}, 32'h3);
        idle(2);
        wb_access(1'b0, 18'h00123, 16'h0000, 2'b11);
        check_value("rd0_data", {16'd0, t_rdata}, 32'hBE12);
        idle(2);

        // Back-to-back read at top address then write at address zero
        wb_access(1'b0, 18'h3FFFF, 16'h0000, 2'b11);
        check_value("b2b_rd_addr", {14'd0, t_a}, 32'h3FFFF);
        check_value("b2b_rd_data", {16'd0, t_rdata}, 32'hA5C3);
        wb_access(1'b1, 18'h00000, 16'h1357, 2'b11);
        check_value("b2b_wr_ce_fall", t_ce_fall, 2);
        check_value("b2b_wr_addr", {14'd0, t_a}, 32'h0);
        check_value("b2b_wr_ack_cyc", t_ack_cyc, 6);
        idle(2);
        wb_access(1'b0, 18'h00000, 16'h0000, 2'b11);
        check_value("b2b_rdback", {16'd0, t_rdata}, 32'h1357);
        idle(2);

        // Write followed immediately by a read (turnaround cycle when enabled)
        wb_access(1'b1, 18'h00200, 16'h4242, 2'b11);
        wb_access(1'b0, 18'h00200, 16'h0000, 2'b11);
`ifdef WB_SRAM_TURNAROUND_EN
        check_value("wr_rd_ce_fall", t_ce_fall, 3);
        check_value("wr_rd_ack_cyc", t_ack_cyc, 5);
`else
        check_value("wr_rd_ce_fall", t_ce_fall, 2);
        check_value("wr_rd_ack_cyc", t_ack_cyc, 4);
`endif
        check_value("wr_rd_data", {16'd0, t_rdata}, 32'h4242);
        idle(1);
        check_value("wr_rd_ack_pulse", {31'd0, wb_bus.ack_o}, 32'd0);
        idle(2);

        // Abort during the write pulse
        wb_bus.cyc_i = 1'b1; wb_bus.stb_i = 1'b1; wb_bus.we_i = 1'b1;
        wb_bus.adr_i = 18'h00055; wb_bus.dat_i = 16'h7777; wb_bus.sel_i = 2'b11;
        acks = 0;
        waited = 0;
        while (sram_we_n && waited < 10) begin
            @(negedge clk_i);
            if (wb_bus.ack_o) acks++;
            waited++;
        end
        check_value("abort_we_seen", {31'd0, sram_we_n}, 32'd0);
        wb_bus.cyc_i = 1'b0; wb_bus.stb_i = 1'b0; wb_bus.we_i = 1'b0;
        @(negedge clk_i);
        if (wb_bus.ack_o) acks++;
        check_value("abort_we_rise", {31'd0, sram_we_n}, 32'd1);
        check_value("abort_hold_ce", {31'd0, sram_ce_n}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i);
            if (wb_bus.ack_o) acks++;
        end
        check_value("abort_no_ack", acks, 0);
        check_value("abort_released", {30'd0, sram_ce_n, sram_dq_oe}, 32'h2);

        // Reset in the middle of a read
        wb_bus.cyc_i = 1'b1; wb_bus.stb_i = 1'b1; wb_bus.we_i = 1'b0;
        wb_bus.adr_i = 18'h00123; wb_bus.sel_i = 2'b11;
        @(negedge clk_i);
        check_value("rstrd_oe_low", {31'd0, sram_oe_n}, 32'd0);
        rst_i = 1'b1;
        @(negedge clk_i);
        check_value("rstrd_strobes", {27'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n}, 32'h1F);
        check_value("rstrd_ack", {31'd0, wb_bus.ack_o}, 32'd0);
        rst_i = 1'b0;
        wb_bus.cyc_i = 1'b0; wb_bus.stb_i = 1'b0;
        idle(2);
        wb_access(1'b0, 18'h00123, 16'h0000, 2'b11);
        check_value("post_rst_data", {16'd0, t_rdata}, 32'hBE12);
        check_value("post_rst_ack_cyc", t_ack_cyc, 3);
        idle(2);

        check_value("oe_we_overlap", n_overlap, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
